// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result handshake between the execute stage and the multiply/divide sequencer
interface muldiv_seq_if #(parameter int WIDTH = 32);
   logic start;
   logic flush;
   logic [2:0] funct3;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic busy;
   logic done;
   logic [WIDTH-1:0] result;
   modport master (output start, flush, funct3, a, b, input busy, done, result);
   modport slave (input start, flush, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer (shift/add multiply, restoring divide)
module muldiv_seq #(parameter int WIDTH = 32) (
   input logic clk,
   input logic rst,
   muldiv_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state;
   logic ld, neg_res, neg_rem, is_div, sa, sb, dz, ovf;
   logic [2:0] fn;
   logic [CW-1:0] ctr;
   logic [WIDTH-1:0] ra, rb, hi, lo, m, ma, mb, quo, rem, sel;
   logic [WIDTH:0] add, sub;
   logic [2*WIDTH-1:0] prod;
   assign is_div = fn[2];
   assign sa = ra[WIDTH-1] & (is_div ? !fn[0] : (fn[1] ^ fn[0]));
   assign sb = rb[WIDTH-1] & (is_div ? !fn[0] : (fn[1:0] == 2'b01));
   assign ma = sa ? -ra : ra;
   assign mb = sb ? -rb : rb;
   assign dz = is_div && rb == '0;
   assign ovf = is_div && !fn[0] && ra == {1'b1, {(WIDTH-1){1'b0}}} && rb == '1;
   // hi:lo is the product during multiply and remainder:quotient during divide
   assign add = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
   assign sub = {hi, lo[WIDTH-1]} - {1'b0, m};
   assign prod = neg_res ? -{hi, lo} : {hi, lo};
   assign quo = neg_res ? -lo : lo;
   assign rem = neg_rem ? -hi : hi;
   assign sel = fn == 3'b000 ? prod[WIDTH-1:0] : !is_div ? prod[2*WIDTH-1:WIDTH] : fn[1] ? rem : quo;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ld <= 1'b0;
         ctr <= '0;
         fn <= '0;
         ra <= '0;
         rb <= '0;
         hi <= '0;
         lo <= '0;
         m <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.result <= '0;
      end else if (bus.flush) begin
         state <= IDLE;
         ld <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ld) begin
                  // operands were captured last cycle; resolve signs and special cases now
                  ld <= 1'b0;
                  bus.busy <= 1'b1;
                  m <= mb;
                  if (dz || ovf) begin
                     hi <= dz ? ra : '0;
                     lo <= dz ? '1 : ra;
                     neg_res <= 1'b0;
                     neg_rem <= 1'b0;
                     state <= FIX;
                  end else begin
                     hi <= '0;
                     lo <= ma;
                     neg_res <= sa ^ sb;
                     neg_rem <= sa;
                     ctr <= CW'(WIDTH - 1);
                     state <= CALC;
                  end
               end else if (bus.start) begin
                  ld <= 1'b1;
                  fn <= bus.funct3;
                  ra <= bus.a;
                  rb <= bus.b;
               end
            end
            CALC: begin
               ctr <= ctr - 1'b1;
               if (!is_div) begin
                  {hi, lo} <= {add, lo[WIDTH-1:1]};
               end else begin
                  hi <= sub[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : sub[WIDTH-1:0];
                  lo <= {lo[WIDTH-2:0], !sub[WIDTH]};
               end
               if (ctr == '0) state <= FIX;
            end
            FIX: begin
               bus.result <= sel;
               bus.done <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
